// File: rtl/fifo_pkg.sv
// Shared defaults and state encoding for the FIFO burst reader.
package fifo_pkg;
  localparam int FWIDTH_DEF = 32;
  localparam int CNTW_DEF   = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } rdState_t;
endpackage

// File: rtl/fifo_burst_reader_if.sv
// Downstream valid/ready word stream leaving the burst reader.
interface fifo_burst_reader_if
  import fifo_pkg::*;
  #(parameter int FWIDTH = FWIDTH_DEF);
  logic [FWIDTH-1:0] Out_Data;
  logic              Out_Valid;
  logic              Out_Ready;

  modport master (output Out_Data, output Out_Valid, input Out_Ready);
  modport slave  (input Out_Data, input Out_Valid, output Out_Ready);
endinterface

// File: rtl/fifo_burst_reader_skid_buf2.sv
// Two-entry registered valid/ready buffer; slot 0 is always the head word.
module skid_buf2 #(
  parameter int FWIDTH = 32
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              flush,
  input  logic              push,
  input  logic [FWIDTH-1:0] pushData,
  input  logic              popReady,
  output logic [1:0]        count,
  output logic [FWIDTH-1:0] headData,
  output logic              headValid
);
  logic [FWIDTH-1:0] slotReg [2];
  logic [1:0]        countReg;
  logic              pop;

  assign headValid = (countReg != 2'd0);
  assign pop       = headValid && popReady;
  assign count     = countReg;
  assign headData  = slotReg[0];

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      countReg   <= 2'd0;
      slotReg[0] <= '0;
      slotReg[1] <= '0;
    end else if (flush) begin
      countReg <= 2'd0;
    end else begin
      countReg <= countReg + {1'b0, push} - {1'b0, pop};
      if (pop && countReg == 2'd2)
        slotReg[0] <= slotReg[1];
      // An incoming word lands in the head slot only if the head is free after this edge
      if (push) begin
        if (countReg == 2'd0 || (countReg == 2'd1 && pop))
          slotReg[0] <= pushData;
        else
          slotReg[1] <= pushData;
      end
    end
  end
endmodule

// File: rtl/fifo_burst_reader.sv
// Read-side burst controller: pops the FIFO on FOutN and forwards words on a registered stream.
module fifo_burst_reader
  import fifo_pkg::*;
#(
  parameter int FWIDTH = FWIDTH_DEF,
  parameter int CNTW   = CNTW_DEF
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic                      Start,
  input  logic                      Abort,
  input  logic [CNTW-1:0]           BurstLen,
  input  logic [FWIDTH-1:0]         F_Data,
  input  logic                      F_EmptyN,
  output logic                      FOutN,
  fifo_burst_reader_if.master       outIf,
  output logic                      Busy,
  output logic                      Done,
  output logic [CNTW-1:0]           WordCnt
);
  rdState_t          stateReg;
  logic [CNTW-1:0]   remainingReg;
  logic [CNTW-1:0]   wordCntReg;
  logic              contModeReg;
  logic              doneReg;
  logic [1:0]        bufCount;
  logic              bufValid;
  logic [FWIDTH-1:0] bufData;
  logic              popFifo;
  logic              handshake;

  // Pop decision deliberately ignores Out_Ready; the skid buffer absorbs the stall
  assign popFifo = (stateReg == RUN) && !Abort && F_EmptyN && (bufCount < 2'd2) &&
                   ((remainingReg != '0) || contModeReg);
  assign FOutN     = !popFifo;
  assign handshake = bufValid && outIf.Out_Ready;

  skid_buf2 #(.FWIDTH(FWIDTH)) uSkid (
    .Clk      (Clk),
    .Rst      (Rst),
    .flush    (Abort),
    .push     (popFifo),
    .pushData (F_Data),
    .popReady (outIf.Out_Ready),
    .count    (bufCount),
    .headData (bufData),
    .headValid(bufValid)
  );

  assign outIf.Out_Data  = bufData;
  assign outIf.Out_Valid = bufValid;
  assign Busy            = (stateReg != IDLE);
  assign Done            = doneReg;
  assign WordCnt         = wordCntReg;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      stateReg     <= IDLE;
      remainingReg <= '0;
      wordCntReg   <= '0;
      contModeReg  <= 1'b0;
      doneReg      <= 1'b0;
    end else begin
      doneReg <= 1'b0;
      if (Abort) begin
        stateReg <= IDLE;
      end else begin
        if (handshake)
          wordCntReg <= wordCntReg + 1'b1;
        case (stateReg)
          IDLE: begin
            if (Start) begin
              remainingReg <= BurstLen;
              contModeReg  <= (BurstLen == '0);
              wordCntReg   <= '0;
              stateReg     <= RUN;
            end
          end
          RUN: begin
            if (popFifo && !contModeReg)
              remainingReg <= remainingReg - 1'b1;
            if (!contModeReg && ((remainingReg == '0) ||
                                 (popFifo && remainingReg == CNTW'(1))))
              stateReg <= DRAIN;
          end
          DRAIN: begin
            if (bufCount == 2'd0) begin
              doneReg  <= 1'b1;
              stateReg <= IDLE;
            end
          end
          default: stateReg <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a behavioural FIFO feeding the read side.
module tb_fifo_burst_reader;
  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        Start = 1'b0;
  logic        Abort = 1'b0;
  logic [15:0] BurstLen = '0;
  logic [31:0] F_Data;
  logic        F_EmptyN;
  logic        FOutN;
  logic        Busy;
  logic        Done;
  logic [15:0] WordCnt;

  always #5 Clk = ~Clk;

  fifo_burst_reader_if #(.FWIDTH(32)) outIf ();

  fifo_burst_reader #(.FWIDTH(32), .CNTW(16)) dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .Start   (Start),
    .Abort   (Abort),
    .BurstLen(BurstLen),
    .F_Data  (F_Data),
    .F_EmptyN(F_EmptyN),
    .FOutN   (FOutN),
    .outIf   (outIf),
    .Busy    (Busy),
    .Done    (Done),
    .WordCnt (WordCnt)
  );

  // Behavioural FIFO: head word is visible whenever non-empty, popped on FOutN=0 edges
  logic [31:0] fifoArr [0:63];
  logic [6:0]  rdPtr = '0;
  logic [6:0]  wrPtr = '0;
  assign F_EmptyN = (rdPtr != wrPtr);
  assign F_Data   = fifoArr[rdPtr[5:0]];

  int          cyc = 0;
  int          doneCnt = 0;
  int          emptyPopErr = 0;
  int          popCyc [$];
  logic [31:0] rxData [$];
  int          rxCyc [$];

  always @(posedge Clk) begin
    cyc <= cyc + 1;
    if (!FOutN) begin
      rdPtr <= rdPtr + 7'd1;
      popCyc.push_back(cyc);
      if (!F_EmptyN) emptyPopErr <= emptyPopErr + 1;
    end
    if (outIf.Out_Valid && outIf.Out_Ready) begin
      rxData.push_back(outIf.Out_Data);
      rxCyc.push_back(cyc);
    end
    if (Done) doneCnt <= doneCnt + 1;
  end

  int vecCnt = 0;
  int missCnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecCnt++;
    if (obs !== exp) begin
      missCnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkRx(input string tag, input int base, input int idx, input logic [31:0] exp);
    if (rxData.size() > base + idx) chk(tag, rxData[base + idx], exp);
    else                            chk(tag, ~exp, exp);
  endtask

  task automatic fifoPush(input logic [31:0] w);
    fifoArr[wrPtr[5:0]] = w;
    wrPtr = wrPtr + 7'd1;
  endtask

  task automatic runCycles(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic startBurst(input logic [15:0] len);
    BurstLen = len;
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int maxCyc);
    bit seen = 1'b0;
    for (int i = 0; i < maxCyc && !seen; i++) begin
      @(negedge Clk);
      if (Done) seen = 1'b1;
    end
    chk(tag, {31'd0, seen}, 32'd1);
  endtask

  int pb, rb, db;

  initial begin
    outIf.Out_Ready = 1'b0;
    runCycles(2);
    chk("rst_foutn", {31'd0, FOutN}, 32'd1);
    chk("rst_valid", {31'd0, outIf.Out_Valid}, 32'd0);
    chk("rst_data", outIf.Out_Data, 32'd0);
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_done", {31'd0, Done}, 32'd0);
    chk("rst_wcnt", {16'd0, WordCnt}, 32'd0);
    Rst = 1'b0;
    runCycles(2);

    // Burst of 4 with downstream always ready
    for (int i = 0; i < 8; i++) fifoPush(32'hA0 + i);
    outIf.Out_Ready = 1'b1;
    pb = popCyc.size(); rb = rxData.size(); db = doneCnt;
    startBurst(16'd4);
    waitDone("t2_done_seen", 20);
    @(negedge Clk);
    chk("t2_done_pulse", {31'd0, Done}, 32'd0);
    chk("t2_done_cnt", doneCnt - db, 32'd1);
    chk("t2_pops", popCyc.size() - pb, 32'd4);
    chk("t2_pop_span", (popCyc.size() >= pb + 4) ? popCyc[pb+3] - popCyc[pb] : -1, 32'd3);
    chk("t2_rx_cnt", rxData.size() - rb, 32'd4);
    for (int i = 0; i < 4; i++) chkRx("t2_rx_data", rb, i, 32'hA0 + i);
    chk("t2_latency", (rxCyc.size() > rb && popCyc.size() > pb) ? rxCyc[rb] - popCyc[pb] : -1, 32'd1);
    chk("t2_rx_span", (rxCyc.size() >= rb + 4) ? rxCyc[rb+3] - rxCyc[rb] : -1, 32'd3);
    chk("t2_wcnt", {16'd0, WordCnt}, 32'd4);
    chk("t2_busy", {31'd0, Busy}, 32'd0);
    chk("t2_fifo_left", {25'd0, wrPtr - rdPtr}, 32'd4);
    chk("t2_fifo_head", F_Data, 32'hA4);
    $display("t2 burst4: pops=%0d words=%0d", popCyc.size() - pb, rxData.size() - rb);

    // Burst of 6 with downstream stalled: buffer fills at two words
    fifoPush(32'hB0); fifoPush(32'hB1);
    outIf.Out_Ready = 1'b0;
    pb = popCyc.size(); rb = rxData.size(); db = doneCnt;
    startBurst(16'd6);
    runCycles(6);
    chk("t3_stall_pops", popCyc.size() - pb, 32'd2);
    chk("t3_stall_foutn", {31'd0, FOutN}, 32'd1);
    chk("t3_stall_valid", {31'd0, outIf.Out_Valid}, 32'd1);
    chk("t3_stall_data", outIf.Out_Data, 32'hA4);
    runCycles(3);
    chk("t3_hold_data", outIf.Out_Data, 32'hA4);
    chk("t3_hold_pops", popCyc.size() - pb, 32'd2);
    outIf.Out_Ready = 1'b1;
    waitDone("t3_done_seen", 30);
    chk("t3_pops", popCyc.size() - pb, 32'd6);
    chk("t3_rx_cnt", rxData.size() - rb, 32'd6);
    chkRx("t3_rx0", rb, 0, 32'hA4); chkRx("t3_rx1", rb, 1, 32'hA5);
    chkRx("t3_rx2", rb, 2, 32'hA6); chkRx("t3_rx3", rb, 3, 32'hA7);
    chkRx("t3_rx4", rb, 4, 32'hB0); chkRx("t3_rx5", rb, 5, 32'hB1);
    chk("t3_wcnt", {16'd0, WordCnt}, 32'd6);
    $display("t3 stalled burst6: pops=%0d words=%0d", popCyc.size() - pb, rxData.size() - rb);

    // FIFO runs dry mid-burst, then refills
    @(negedge Clk);
    fifoPush(32'hC0); fifoPush(32'hC1);
    pb = popCyc.size(); rb = rxData.size(); db = doneCnt;
    startBurst(16'd5);
    runCycles(6);
    chk("t4_dry_pops", popCyc.size() - pb, 32'd2);
    chk("t4_dry_busy", {31'd0, Busy}, 32'd1);
    chk("t4_dry_foutn", {31'd0, FOutN}, 32'd1);
    chk("t4_dry_wcnt", {16'd0, WordCnt}, 32'd2);
    chk("t4_dry_nodone", doneCnt - db, 32'd0);
    fifoPush(32'hC2); fifoPush(32'hC3); fifoPush(32'hC4);
    waitDone("t4_done_seen", 20);
    chk("t4_pops", popCyc.size() - pb, 32'd5);
    for (int i = 0; i < 5; i++) chkRx("t4_rx_data", rb, i, 32'hC0 + i);
    chk("t4_wcnt", {16'd0, WordCnt}, 32'd5);
    $display("t4 dry fifo burst5: pops=%0d words=%0d", popCyc.size() - pb, rxData.size() - rb);

    // Abort with two words buffered and the FIFO still non-empty
    @(negedge Clk);
    for (int i = 0; i < 4; i++) fifoPush(32'hD0 + i);
    outIf.Out_Ready = 1'b0;
    pb = popCyc.size(); rb = rxData.size(); db = doneCnt;
    startBurst(16'd10);
    runCycles(4);
    chk("t5_pre_pops", popCyc.size() - pb, 32'd2);
    chk("t5_pre_emptyn", {31'd0, F_EmptyN}, 32'd1);
    Abort = 1'b1;
    #1;
    chk("t5_abort_foutn", {31'd0, FOutN}, 32'd1);
    @(negedge Clk);
    Abort = 1'b0;
    chk("t5_valid", {31'd0, outIf.Out_Valid}, 32'd0);
    chk("t5_busy", {31'd0, Busy}, 32'd0);
    chk("t5_pops", popCyc.size() - pb, 32'd2);
    runCycles(2);
    chk("t5_nodone", doneCnt - db, 32'd0);
    outIf.Out_Ready = 1'b1;
    rb = rxData.size();
    startBurst(16'd1);
    waitDone("t5_done_seen", 20);
    chk("t5_rx_cnt", rxData.size() - rb, 32'd1);
    chkRx("t5_rx_next", rb, 0, 32'hD2);
    $display("t5 abort then burst1: word=%0h", (rxData.size() > rb) ? rxData[rb] : 32'd0);

    // Continuous mode: 20 words, no Done, Abort keeps WordCnt
    @(negedge Clk);
    for (int i = 0; i < 19; i++) fifoPush(32'h100 + i);
    pb = popCyc.size(); rb = rxData.size(); db = doneCnt;
    startBurst(16'd0);
    runCycles(30);
    chk("t6_pops", popCyc.size() - pb, 32'd20);
    chk("t6_rx_cnt", rxData.size() - rb, 32'd20);
    chkRx("t6_rx_first", rb, 0, 32'hD3);
    for (int i = 1; i < 20; i++) chkRx("t6_rx_data", rb, i, 32'h100 + i - 1);
    chk("t6_busy", {31'd0, Busy}, 32'd1);
    chk("t6_nodone", doneCnt - db, 32'd0);
    Abort = 1'b1;
    @(negedge Clk);
    Abort = 1'b0;
    chk("t6_abort_busy", {31'd0, Busy}, 32'd0);
    chk("t6_abort_wcnt", {16'd0, WordCnt}, 32'd20);
    chk("t6_abort_done", {31'd0, Done}, 32'd0);
    $display("t6 continuous: pops=%0d words=%0d", popCyc.size() - pb, rxData.size() - rb);

    // Asynchronous reset in the middle of a stalled burst
    for (int i = 0; i < 4; i++) fifoPush(32'hF0 + i);
    outIf.Out_Ready = 1'b0;
    startBurst(16'd3);
    runCycles(4);
    chk("t1_pre_valid", {31'd0, outIf.Out_Valid}, 32'd1);
    Rst = 1'b1;
    #1;
    chk("t1_foutn", {31'd0, FOutN}, 32'd1);
    chk("t1_valid", {31'd0, outIf.Out_Valid}, 32'd0);
    chk("t1_busy", {31'd0, Busy}, 32'd0);
    chk("t1_wcnt", {16'd0, WordCnt}, 32'd0);
    @(negedge Clk);
    Rst = 1'b0;
    runCycles(3);
    chk("t1_idle_busy", {31'd0, Busy}, 32'd0);
    chk("t1_idle_foutn", {31'd0, FOutN}, 32'd1);
    chk("t1_fifo_kept", {25'd0, wrPtr - rdPtr}, 32'd2);
    $display("t1 reset mid-burst: fifo words left=%0d", wrPtr - rdPtr);

    chk("empty_pop_never", emptyPopErr, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, missCnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
